// File: rtl/rf_pkg.sv
// Shared types and sizes for the register file and its operand-fetch stage.
package rf_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    OF_EMPTY = 1'b0,
    OF_FULL  = 1'b1
  } of_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with hazard lookups
// that already see this cycle's writeback clear.
module rf_scoreboard #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_addr_0,
  input  logic [ADDR_W-1:0] q_addr_1,
  input  logic [ADDR_W-1:0] q_addr_2,
  output logic [2:0]        q_busy
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // Set is applied after clear so a same-address set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    busy_nxt = (busy & ~clr_mask) | set_mask;
  end

  always_comb begin
    q_busy    = '0;
    q_busy[0] = busy[q_addr_0] && !(clr_en && (clr_addr == q_addr_0));
    q_busy[1] = busy[q_addr_1] && !(clr_en && (clr_addr == q_addr_1));
    q_busy[2] = busy[q_addr_2] && !(clr_en && (clr_addr == q_addr_2));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, bypasses writeback data,
// blocks on RAW/WAW hazards and holds one registered operand bundle.
module operand_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs0,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [1:0]        in_use,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wr,
  output logic [1:0]        rf_read_en,
  output logic [ADDR_W-1:0] rf_raddr_0,
  output logic [ADDR_W-1:0] rf_raddr_1,
  input  logic [DATA_W-1:0] rf_rdata_0,
  input  logic [DATA_W-1:0] rf_rdata_1,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op0,
  output logic [DATA_W-1:0] out_op1,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr,
  output logic [15:0]       stall_cnt
);

  import rf_pkg::*;

  of_state_e   state;
  of_state_e   state_nxt;
  logic [2:0]  q_busy;
  logic        hazard;
  logic        accept;
  logic        stall;
  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (accept && in_wr),
    .set_addr (in_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q_addr_0 (in_rs0),
    .q_addr_1 (in_rs1),
    .q_addr_2 (in_rd),
    .q_busy   (q_busy)
  );

  assign rf_read_en = in_use & {2{in_valid}};
  assign rf_raddr_0 = in_rs0;
  assign rf_raddr_1 = in_rs1;

  assign hazard   = (in_use[0] && q_busy[0]) || (in_use[1] && q_busy[1]) || (in_wr && q_busy[2]);
  assign in_ready = !hazard && ((state == OF_EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;
  assign stall    = in_valid && !in_ready;

  // Same-cycle writeback takes priority over the (stale) register file read.
  always_comb begin
    op0 = '0;
    op1 = '0;
    if (in_use[0]) op0 = (wb_valid && (wb_addr == in_rs0)) ? wb_data : rf_rdata_0;
    if (in_use[1]) op1 = (wb_valid && (wb_addr == in_rs1)) ? wb_data : rf_rdata_1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OF_EMPTY: if (accept) state_nxt = OF_FULL;
      OF_FULL:  if (out_ready && !accept) state_nxt = OF_EMPTY;
      default:  state_nxt = OF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OF_EMPTY;
      out_valid <= 1'b0;
      out_op0   <= '0;
      out_op1   <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == OF_FULL);
      if (accept) begin
        out_op0 <= op0;
        out_op1 <= op1;
        out_rd  <= in_rd;
        out_wr  <= in_wr;
      end
      if (stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch with a behavioural register file and stage model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs0, in_rs1, in_rd;
  logic [1:0]  in_use;
  logic        in_wr;
  logic [1:0]  rf_read_en;
  logic [3:0]  rf_raddr_0, rf_raddr_1;
  logic [31:0] rf_rdata_0, rf_rdata_1;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op0, out_op1;
  logic [3:0]  out_rd;
  logic        out_wr;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rf_mem [16];

  always #5 clk = ~clk;

  operand_fetch #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_use(in_use), .in_rd(in_rd), .in_wr(in_wr),
    .rf_read_en(rf_read_en), .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1),
    .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op0(out_op0), .out_op1(out_op1), .out_rd(out_rd), .out_wr(out_wr),
    .stall_cnt(stall_cnt)
  );

  // Register file stand-in: synchronous write, combinational read.
  always @(posedge clk) if (wb_valid) rf_mem[wb_addr] <= wb_data;
  assign rf_rdata_0 = rf_mem[rf_raddr_0];
  assign rf_rdata_1 = rf_mem[rf_raddr_1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: which registers have writes outstanding, plus the bundle held.
  bit        m_busy [16];
  bit        m_full;
  bit [31:0] m_op0, m_op1;
  bit [3:0]  m_rd;
  bit        m_wr;
  int        m_cnt;

  function automatic bit pending(input bit [3:0] r);
    return m_busy[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic bit [31:0] fetch(input bit used, input bit [3:0] r);
    if (!used) return 32'h0;
    if (wb_valid && wb_addr == r) return wb_data;
    return rf_mem[r];
  endfunction

  always @(negedge clk) begin
    bit haz, exp_ready, acc;
    if (!reset_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_full = 1'b0; m_op0 = '0; m_op1 = '0; m_rd = '0; m_wr = 1'b0; m_cnt = 0;
    end
    haz = (in_use[0] && pending(in_rs0)) || (in_use[1] && pending(in_rs1)) || (in_wr && pending(in_rd));
    exp_ready = !haz && (!m_full || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("rf_read_en", 32'(rf_read_en), 32'(in_use & {2{in_valid}}));
    chk("rf_raddr_0", 32'(rf_raddr_0), 32'(in_rs0));
    chk("rf_raddr_1", 32'(rf_raddr_1), 32'(in_rs1));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (m_full) begin
      chk("out_op0", out_op0, m_op0);
      chk("out_op1", out_op1, m_op1);
      chk("out_rd", 32'(out_rd), 32'(m_rd));
      chk("out_wr", 32'(out_wr), 32'(m_wr));
    end
    if (reset_n) begin
      acc = in_valid && exp_ready;
      if (in_valid && !exp_ready && m_cnt < 65535) m_cnt++;
      if (acc) begin
        m_op0 = fetch(in_use[0], in_rs0);
        m_op1 = fetch(in_use[1], in_rs1);
        m_rd  = in_rd;
        m_wr  = in_wr;
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (acc && in_wr) m_busy[in_rd] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit v, input bit [3:0] rs0, input bit [3:0] rs1,
                       input bit [1:0] use_, input bit [3:0] rd, input bit wr);
    in_valid = v; in_rs0 = rs0; in_rs1 = rs1; in_use = use_; in_rd = rd; in_wr = wr;
  endtask

  task automatic wb(input bit v, input bit [3:0] a, input bit [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b1;
    issue(0, 0, 0, 2'b00, 0, 0);
    wb(0, 0, 0);
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", 32'(in_ready), 32'd1);
    chk("idle rf_read_en", 32'(rf_read_en), 32'd0);
    chk("idle out_valid", 32'(out_valid), 32'd0);
    chk("idle out_op0", out_op0, 32'd0);
    chk("idle out_op1", out_op1, 32'd0);
    chk("idle stall_cnt", 32'(stall_cnt), 32'd0);

    // Preload r3 and read it on both ports.
    step(); wb(1, 3, 32'hA5A5_0003);
    step(); wb(0, 0, 0); issue(1, 3, 3, 2'b11, 0, 0);
    @(negedge clk);
    chk("read_en both", 32'(rf_read_en), 32'd3);
    step(); issue(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("r3 valid", 32'(out_valid), 32'd1);
    chk("r3 op0", out_op0, 32'hA5A5_0003);
    chk("r3 op1", out_op1, 32'hA5A5_0003);

    // RAW on r5 released by a same-cycle writeback.
    step(); issue(1, 0, 0, 2'b00, 5, 1);
    step(); issue(1, 5, 0, 2'b01, 0, 0);
    @(negedge clk);
    chk("raw r5 stall", 32'(in_ready), 32'd0);
    step(); step();
    @(negedge clk);
    chk("stall_cnt 2", 32'(stall_cnt), 32'd2);
    step(); wb(1, 5, 32'h1234_5678);
    @(negedge clk);
    chk("raw r5 release", 32'(in_ready), 32'd1);
    step(); wb(0, 0, 0); issue(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("bypass op0", out_op0, 32'h1234_5678);
    chk("stall_cnt 3", 32'(stall_cnt), 32'd3);
    step(); issue(1, 5, 0, 2'b01, 0, 0);
    @(negedge clk);
    chk("r5 not busy", 32'(in_ready), 32'd1);
    step(); issue(0, 0, 0, 2'b00, 0, 0);

    // Backpressure: hold the bundle while a second instruction waits.
    step(); out_ready = 1'b0; issue(1, 0, 3, 2'b10, 1, 0);
    @(negedge clk);
    chk("bp accept A", 32'(in_ready), 32'd1);
    step(); issue(1, 3, 0, 2'b01, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp blocked", 32'(in_ready), 32'd0);
      chk("bp hold op1", out_op1, 32'hA5A5_0003);
      chk("bp hold rd", 32'(out_rd), 32'd1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release", 32'(in_ready), 32'd1);
    step(); issue(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("bp B op0", out_op0, 32'hA5A5_0003);
    chk("bp B rd", 32'(out_rd), 32'd2);

    // Set wins over clear on r7.
    step(); issue(1, 0, 0, 2'b00, 7, 1);
    step(); issue(1, 0, 0, 2'b00, 7, 1); wb(1, 7, 32'h0000_7777);
    @(negedge clk);
    chk("waw r7 cleared", 32'(in_ready), 32'd1);
    step(); wb(0, 0, 0); issue(1, 7, 0, 2'b01, 0, 0);
    @(negedge clk);
    chk("r7 still busy", 32'(in_ready), 32'd0);
    step(); wb(1, 7, 32'h0000_8888);
    step(); wb(0, 0, 0); issue(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("r7 bypass op0", out_op0, 32'h0000_8888);

    // Asynchronous reset in the middle of a stall.
    step(); issue(1, 0, 0, 2'b00, 5, 1);
    step(); issue(1, 5, 0, 2'b01, 0, 0); out_ready = 1'b0;
    @(negedge clk);
    chk("pre-reset stall", 32'(in_ready), 32'd0);
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async out_op0", out_op0, 32'd0);
    chk("async out_wr", 32'(out_wr), 32'd0);
    step(); reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("busy cleared", 32'(in_ready), 32'd1);
    step(); issue(0, 0, 0, 2'b00, 0, 0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
